// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Passive monitor for a multiplexed common-anode 7-segment display bus.
//   Samples the active-low anodes and segments, waits until a digit's
//   pattern has been stable for STABLE_CYCLES samples, decodes the glyph
//   back to a hex nibble and, once every digit has been captured, presents
//   the assembled frame.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   an_n         digit enables, active low (bit k = digit k)
//   seg_n        segments {a,b,c,d,e,f,g}, active low
//   value        last complete frame, digit k in bits [4k+3:4k]
//   value_valid  one-cycle pulse when value is updated
//   pattern_err  one-cycle pulse: stable pattern is not a hex glyph
//   anode_err    one-cycle pulse: more than one anode low in a sample
//   err_digit    digit index of the latest pattern_err
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic                    value_valid,
  output logic                    pattern_err,
  output logic                    anode_err,
  output logic [2:0]              err_digit
);

  localparam logic [7:0] STABLE_Q = 8'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0]   an_q, an_prev;
  logic [6:0]              seg_q, seg_prev;
  logic [7:0]              cnt, cnt_next;
  logic                    done;
  logic [NUM_DIGITS-1:0]   mask;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_next;

  logic       change;
  logic [3:0] nlow;
  logic [2:0] dig;
  logic       capture;
  logic       glyph_ok;
  logic [3:0] nibble;
  logic       frame_full;

  function automatic logic [4:0] glyph_decode(input logic [6:0] s);
    logic [4:0] r;
    r = '0;
    case (s)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001111: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0001000: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    change = ({an_q, seg_q} != {an_prev, seg_prev});

    // Count low anodes and remember which one; index is only meaningful
    // when exactly one is low.
    nlow = '0;
    dig  = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        nlow = nlow + 4'd1;
        dig  = i[2:0];
      end
    end

    if (change)
      cnt_next = 8'd1;
    else if (cnt >= STABLE_Q)
      cnt_next = STABLE_Q;
    else
      cnt_next = cnt + 8'd1;

    // done blocks a second capture while the counter sits saturated.
    capture = !change && (cnt_next == STABLE_Q) && !done && (nlow == 4'd1);

    {glyph_ok, nibble} = glyph_decode(seg_q);

    shadow_next = shadow;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i])
        shadow_next[4*i +: 4] = nibble;
    end

    frame_full = ((mask | ~an_q) == '1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an_q        <= '1;
      seg_q       <= '1;
      an_prev     <= '1;
      seg_prev    <= '1;
      cnt         <= '0;
      done        <= 1'b0;
      mask        <= '0;
      shadow      <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= 1'b0;
      err_digit   <= '0;
    end else begin
      an_q        <= an_n;
      seg_q       <= seg_n;
      an_prev     <= an_q;
      seg_prev    <= seg_q;
      cnt         <= cnt_next;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
      anode_err   <= (nlow > 4'd1);

      if (change)
        done <= 1'b0;
      else if (capture)
        done <= 1'b1;

      if (capture) begin
        if (glyph_ok) begin
          shadow <= shadow_next;
          if (frame_full) begin
            value       <= shadow_next;
            value_valid <= 1'b1;
            mask        <= '0;
          end else begin
            mask <= mask | ~an_q;
          end
        end else begin
          pattern_err <= 1'b1;
          err_digit   <= dig;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=8).
// A dwell-level model predicts every output each cycle; literal checks
// after each scenario pin the model to hand-computed results.
module tb_seg7_scan_capture;

  localparam int ND = 4;
  localparam int SC = 8;

  logic          clk;
  logic          reset;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic [15:0]   value;
  logic          value_valid;
  logic          pattern_err;
  logic          anode_err;
  logic [2:0]    err_digit;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .an_n(an_n), .seg_n(seg_n),
    .value(value), .value_valid(value_valid), .pattern_err(pattern_err),
    .anode_err(anode_err), .err_digit(err_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int n_vv   = 0;
  int n_perr = 0;
  int n_aerr = 0;

  // Glyph table indexed by nibble.
  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model expectations for the outputs after the most recent edge.
  logic [15:0] exp_value;
  logic        exp_vv, exp_perr, exp_aerr;
  logic [2:0]  exp_errd;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Behavioural model: works on the sequence of samples taken at each edge.
  // A dwell captures once, at the edge where its run of identical samples
  // reaches SC; the result appears one edge later.
  initial begin
    logic [10:0] s_last, s_prev;
    int          run;
    logic [3:0]  sh [ND];
    logic [ND-1:0] m_mask;
    int          nlow, k, nib;
    run = 0;
    s_last = '1;
    s_prev = '1;
    m_mask = '0;
    for (int i = 0; i < ND; i++) sh[i] = 4'h0;
    forever begin
      @(posedge clk);
      if (reset) begin
        exp_value = '0; exp_vv = 0; exp_perr = 0; exp_aerr = 0; exp_errd = '0;
        run = 0; s_prev = '1; m_mask = '0;
        for (int i = 0; i < ND; i++) sh[i] = 4'h0;
        s_last = '1;
      end else begin
        exp_vv = 0;
        exp_perr = 0;
        run = (s_last == s_prev) ? run + 1 : 1;
        nlow = 0;
        k = 0;
        for (int i = 0; i < ND; i++)
          if (!s_last[7+i]) begin nlow++; k = i; end
        exp_aerr = (nlow > 1);
        if (run == SC && nlow == 1) begin
          nib = -1;
          for (int g = 0; g < 16; g++)
            if (glyph[g] == s_last[6:0]) nib = g;
          if (nib < 0) begin
            exp_perr = 1;
            exp_errd = 3'(k);
          end else begin
            sh[k] = 4'(nib);
            m_mask[k] = 1'b1;
            if (m_mask == '1) begin
              exp_value = {sh[3], sh[2], sh[1], sh[0]};
              exp_vv = 1;
              m_mask = '0;
            end
          end
        end
        s_prev = s_last;
        s_last = {an_n, seg_n};
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse tallies.
  initial begin
    forever begin
      @(negedge clk);
      check("value", 32'(value), 32'(exp_value));
      check("value_valid", 32'(value_valid), 32'(exp_vv));
      check("pattern_err", 32'(pattern_err), 32'(exp_perr));
      check("anode_err", 32'(anode_err), 32'(exp_aerr));
      check("err_digit", 32'(err_digit), 32'(exp_errd));
      if (value_valid === 1'b1) n_vv++;
      if (pattern_err === 1'b1) n_perr++;
      if (anode_err === 1'b1) n_aerr++;
    end
  end

  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011, A3 = 4'b0111;

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int cycles);
    an_n  = an;
    seg_n = seg;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic scan1234();
    dwell(A0, 7'b1001100, 16);
    dwell(A1, 7'b0000110, 16);
    dwell(A2, 7'b0010010, 16);
    dwell(A3, 7'b1001111, 16);
  endtask

  initial begin
    reset = 1'b1;
    an_n  = '1;
    seg_n = '1;
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_valid", 32'(value_valid), 32'h0);
    check("reset_errd", 32'(err_digit), 32'h0);
    reset = 1'b0;
    dwell('1, '1, 4);

    // Full scans of 0x1234.
    scan1234();
    check("scan1_value", 32'(value), 32'h1234);
    check("scan1_nvv", 32'(n_vv), 32'd1);
    scan1234();
    check("scan2_nvv", 32'(n_vv), 32'd2);

    // Digit2 dwell too short: frame waits for a long enough dwell.
    dwell(A0, 7'b1001100, 16);
    dwell(A1, 7'b0000110, 16);
    dwell(A2, 7'b0010010, 5);
    dwell(A3, 7'b1001111, 16);
    check("short_nvv", 32'(n_vv), 32'd2);
    dwell(A2, 7'b0010010, 16);
    check("short_done_nvv", 32'(n_vv), 32'd3);
    check("short_value", 32'(value), 32'h1234);

    // Dash on digit1: one pattern error, frame not completed.
    dwell(A0, 7'b0100100, 16);
    dwell(A1, 7'b1111110, 16);
    dwell(A2, 7'b0100000, 16);
    dwell(A3, 7'b0000100, 16);
    check("dash_nperr", 32'(n_perr), 32'd1);
    check("dash_errd", 32'(err_digit), 32'd1);
    check("dash_nvv", 32'(n_vv), 32'd3);
    check("dash_value", 32'(value), 32'h1234);

    // Two anodes low for three cycles.
    dwell(4'b1100, 7'b0000000, 3);
    dwell(A0, 7'b0111000, 16);
    check("anode_naerr", 32'(n_aerr), 32'd3);
    dwell(A1, 7'b0110000, 16);
    // Digits 2 and 3 are still held from the dash frame.
    check("mixed_value", 32'(value), 32'h96EF);
    dwell(A2, 7'b0110000, 16);
    dwell(A3, 7'b1100000, 16);
    dwell(A0, 7'b0111000, 16);
    dwell(A1, 7'b0110000, 16);
    dwell(A2, 7'b0110000, 16);
    dwell(A3, 7'b1100000, 16);
    check("beef_value", 32'(value), 32'hBEEF);
    check("beef_nvv", 32'(n_vv), 32'd5);

    // Reset mid-frame.
    dwell(A0, 7'b1001100, 16);
    dwell(A1, 7'b0000110, 16);
    check("pre_rst_value", 32'(value), 32'hBE34);
    dwell(A2, 7'b0010010, 16);
    reset = 1'b1;
    dwell('1, '1, 2);
    check("rst_value", 32'(value), 32'h0);
    check("rst_errd", 32'(err_digit), 32'h0);
    reset = 1'b0;
    dwell(A0, 7'b1001100, 16);
    dwell(A1, 7'b0000110, 16);
    dwell(A2, 7'b0010010, 16);
    check("rst_partial_nvv", 32'(n_vv), 32'd6);
    dwell(A3, 7'b1001111, 16);
    check("rst_full_nvv", 32'(n_vv), 32'd7);
    check("rst_full_value", 32'(value), 32'h1234);

    // Static digit0 held for a long time: a single capture only.
    dwell(A0, 7'b0001111, 1000);
    check("static_nvv", 32'(n_vv), 32'd7);
    check("static_nperr", 32'(n_perr), 32'd1);
    check("static_naerr", 32'(n_aerr), 32'd3);
    dwell(A1, 7'b0000110, 16);
    dwell(A2, 7'b0010010, 16);
    dwell(A3, 7'b1001111, 16);
    check("static_value", 32'(value), 32'h1237);
    check("static_final_nvv", 32'(n_vv), 32'd8);

    dwell('1, '1, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Passive monitor for the multiplexed common-anode 7-segment display bus: it samples the active-low digit anodes and segment lines, waits until each digit's pattern is stable, and maps it back to a 4-bit hex nibble. When every digit has been captured once, it presents the assembled value. It sits beside the display scanner in the MIPS_UART top level for self-test and lets benches read back what the display shows.

## Interface
Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), 1..8
- STABLE_CYCLES, 8, consecutive identical samples required before a capture, 2..255

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- an_n  in  NUM_DIGITS  digit enables, active low; bit k selects digit k
- seg_n  in  7  segments {a,b,c,d,e,f,g}, active low (0 = lit); decimal point not monitored
- value  out  4*NUM_DIGITS  last complete frame; digit k in bits [4k+3:4k]
- value_valid  out  1  one-cycle pulse when value is updated
- pattern_err  out  1  one-cycle pulse: stable pattern is not a legal hex glyph
- anode_err  out  1  one-cycle pulse: more than one anode low in a sample
- err_digit  out  3  index of the digit that caused the latest pattern_err; holds until the next error

## Operation
- Input stage: an_n and seg_n are registered once into sample registers (an_q, seg_q) every cycle. All further logic uses the samples.
- Anode classification per sample: exactly one bit low -> active digit k; all bits high -> blank; two or more low -> illegal.
- Stability counter: 8 bits. Cleared to 1 when {an_q, seg_q} differs from the previous sample. Otherwise increments, saturating at STABLE_CYCLES. A dwell that is blank or illegal never captures.
- Capture event: the counter reaches STABLE_CYCLES with an active digit k and the dwell is not yet marked done. The done flag is set and cleared on the next sample change, so one dwell produces at most one capture.
- Glyph inverse map (seg_n abc_defg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F. Any other pattern, including dash 1111110 and all-off 1111111, is illegal.
- Legal capture: the nibble is written into shadow[k], and bit k of captured_mask is set. A repeat capture of the same digit before the frame completes overwrites shadow[k].
- Illegal capture: pulse pattern_err, set err_digit=k, and leave shadow and mask unchanged.
- Frame complete: when captured_mask becomes all ones, value <= shadow (including the nibble captured this cycle) and value_valid pulses. captured_mask is cleared in the same cycle.
- Illegal anode sample: pulse anode_err on every illegal sample, with no capture. Mask and shadow are preserved.
- Reset values: value=0, value_valid=0, pattern_err=0, anode_err=0, err_digit=0, shadow=0, captured_mask=0, counter=0, done=0, and the sample and previous-sample registers all ones (blank).

## Timing
- Pins stable from edge E0 are sampled at E1. The capture decision happens at edge E(STABLE_CYCLES). value, value_valid and pattern_err are registered and change at edge E(STABLE_CYCLES+1).
- anode_err asserts one edge after the illegal sample is registered, i.e. two edges after the pins.
- Minimum capturable dwell is STABLE_CYCLES cycles. Shorter dwells, such as scan ghosting, are ignored silently.
- If a pin change and a capture fall on the same edge, the capture uses the old stable sample and the counter restarts for the new one.
- Reset asserted mid-frame discards partial frame state. The first value_valid after reset requires a full set of NUM_DIGITS fresh captures.
- Holding one digit indefinitely yields one capture, never a repeat.

## Test plan
- Scan 0x1234 with NUM_DIGITS=4, STABLE_CYCLES=8, 16-cycle dwells: digit0 an_n=1110 seg 1001100, digit1 1101 0000110, digit2 1011 0010010, digit3 0111 1001111 -> one value_valid with value=16'h1234, then one per further full scan.
- Same scan but digit2 dwells only 5 cycles -> no value_valid until a later ≥8-cycle dwell of digit2. No errors.
- Digit1 shows dash 1111110 for 16 cycles -> single pattern_err, err_digit=1, frame not completed, value unchanged.
- an_n=1100 for 3 cycles -> anode_err high for 3 cycles. Following correct scan of 0xBEEF -> value=16'hBEEF.
- Reset pulsed after digits 0..2 are captured -> all outputs 0. value_valid only after digits 0..3 are all re-captured.
- Static digit0 showing 0x7 (0001111) for 1000 cycles with the other anodes high -> exactly one capture, no value_valid, no errors.
